// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer for a simple core: FETCH, DECODE, EXEC, MEM,
// WB, with absorbing HALT and FAULT states and a memory wait timeout.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   imem_ack, dmem_ack  memory handshake acknowledges
//   is_load, is_store,
//   is_halt, reg_we     decoder flags for the instruction held in IR
//   imem_req, dmem_req,
//   dmem_we, ir_we,
//   pc_we, rf_we        control strobes, decoded from state and inputs
//   state               current state code
//   halted, fault       stop indicators
//   instret             retired-instruction count
module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_halt,
  input  logic        reg_we,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             retire;
  logic             timeout_hit;

  assign state = cur_state;

  // True when one more unacknowledged cycle makes the wait count reach the limit.
  assign timeout_hit = (32'(wait_cnt) + 32'd1) >= MEM_TIMEOUT;

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (retire) instret <= instret + 32'd1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    nxt_state = cur_state;
    wait_nxt  = wait_cnt;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;

    case (cur_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout_hit) begin
          nxt_state = S_FAULT;
        end else begin
          wait_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_DECODE: nxt_state = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   nxt_state = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        // Load takes precedence when both flags are set.
        dmem_we  = is_store && !is_load;
        if (dmem_ack) begin
          if (is_load) begin
            nxt_state = S_WB;
          end else begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end
        end else if (timeout_hit) begin
          nxt_state = S_FAULT;
        end else begin
          wait_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        rf_we     = reg_we;
        pc_we     = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: nxt_state = S_FETCH;
    endcase

    // Every state change restarts the wait count, so FETCH and MEM start at 0.
    if (nxt_state != cur_state) wait_nxt = '0;

    // Reset suppresses any in-flight request or commit in the same cycle.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001: Parameter MEM_TIMEOUT, default 255, is the maximum cycles a memory request waits for ack before the fault state is entered.
REQ-002: Port clk, input, 1: sole clock, rising-edge.
REQ-003: Port rst, input, 1: reset, synchronous, active-high.
REQ-004: Port imem_ack, input, 1: instruction memory has returned the instruction this cycle.
REQ-005: Port dmem_ack, input, 1: data memory completed the access this cycle.
REQ-006: Ports is_load, is_store, is_halt, reg_we, input, 1 each: decoder flags for the instruction held in IR.
REQ-007: Port imem_req, output, 1: instruction fetch request.
REQ-008: Port dmem_req, output, 1: data access request.
REQ-009: Port dmem_we, output, 1: data access is a store.
REQ-010: Port ir_we, output, 1: capture fetched instruction into IR.
REQ-011: Port pc_we, output, 1: commit the next PC.
REQ-012: Port rf_we, output, 1: register file write enable.
REQ-013: Port state, output, 3: current state code.
REQ-014: Port halted, output, 1: core stopped by halt.
REQ-015: Port fault, output, 1: core stopped by memory timeout.
REQ-016: Port instret, output, 32: retired-instruction count.

Function
REQ-017: State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 is unused and returns to FETCH next cycle.
REQ-018: All control outputs decode combinationally from state and inputs only (Moore, except the ack-qualified pulses below); state and counters are registered.
REQ-019: FETCH: imem_req=1 held until imem_ack; on imem_ack, ir_we=1 for that cycle and next state is DECODE.
REQ-020: DECODE: one cycle; is_halt=1 -> HALT, else -> EXEC.
REQ-021: EXEC: one cycle; is_load or is_store -> MEM, else -> WB.
REQ-022: MEM: dmem_req=1 and dmem_we=is_store held until dmem_ack; on ack, load -> WB, store -> pc_we=1 that cycle, instret increments, next FETCH.
REQ-023: WB: one cycle; rf_we=reg_we, pc_we=1, instret increments, next FETCH.
REQ-024: is_load and is_store both 1 is treated as load.
REQ-025: A 16-bit wait counter clears on entering FETCH or MEM and increments each cycle a request waits without ack; when it reaches MEM_TIMEOUT without ack, next state is FAULT.
REQ-026: An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: normal transition, no fault.
REQ-027: imem_ack outside FETCH and dmem_ack outside MEM are ignored.
REQ-028: HALT and FAULT are absorbing until rst; all request/write outputs are 0 there; halted=1 only in HALT, fault=1 only in FAULT.
REQ-029: instret wraps from 0xFFFFFFFF to 0; a halt instruction does not retire.
REQ-030: rf_we, pc_we, ir_we, dmem_req are never 1 outside the states named above.

Reset
REQ-031: While rst=1 at a clock edge: state<=FETCH, instret<=0, wait counter<=0.
REQ-032: rst overrides any in-flight request; an ack in the reset cycle is ignored.
REQ-033: First cycle after reset release: imem_req=1, all other control outputs 0, halted=0, fault=0.

Verification
REQ-034: ALU op, imem_ack after 2 cycles, reg_we=1 -> states 0,0,0,1,2,4,0; rf_we and pc_we high only in WB; instret=1.
REQ-035: Load, dmem_ack after 3 MEM cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with rf_we=1; instret=1.
REQ-036: Store, dmem_ack immediate -> single MEM cycle, dmem_we=1, pc_we=1 in MEM, rf_we never 1, next FETCH.
REQ-037: is_halt=1 in DECODE -> HALT, halted=1, imem_req=0 for 100 further cycles, instret unchanged; rst -> state=0.
REQ-038: MEM_TIMEOUT=4, imem_ack never -> FAULT after 4 wait cycles, fault=1; repeat with ack on exact timeout cycle -> DECODE, no fault.
REQ-039: rst asserted mid-MEM with dmem_ack same cycle -> state=0, instret=0, no pc_we/rf_we pulse.
